// File: rtl/mod_updown_counter_pkg.sv
// Shared types and helpers for the up/down modulo counter.
// The optional Gray-coded output is enabled with the MOD_CNT_GRAY_OUT_EN macro.
package mod_cnt_pkg;

   typedef enum logic {
      CNT_WRAP = 1'b0,
      CNT_SAT  = 1'b1
   } cnt_mode_e;

   // Widest counter the Gray helper handles; callers zero-extend and truncate.
   localparam int CNT_GRAY_W = 32;

   function automatic logic [CNT_GRAY_W-1:0] bin2gray(input logic [CNT_GRAY_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle of the up/down modulo counter.
// The q_gray signal exists only when MOD_CNT_GRAY_OUT_EN is defined.
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   import mod_cnt_pkg::*;

   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             up;
   cnt_mode_e        sat_mode;
   logic [WIDTH-1:0] max_val;
   logic [WIDTH-1:0] q;
   logic             tc;
   logic             wrap_p;
   logic             sat;
`ifdef MOD_CNT_GRAY_OUT_EN
   logic [WIDTH-1:0] q_gray;
`endif

   modport master (
      output clr, load, load_val, en, up, sat_mode, max_val,
      input  q, tc, wrap_p, sat
`ifdef MOD_CNT_GRAY_OUT_EN
      , input q_gray
`endif
   );

   modport slave (
      input  clr, load, load_val, en, up, sat_mode, max_val,
      output q, tc, wrap_p, sat
`ifdef MOD_CNT_GRAY_OUT_EN
      , output q_gray
`endif
   );

endinterface

// File: rtl/mod_updown_counter_next.sv
// Combinational next-count, wrap and saturate decode for mod_updown_counter.
module mod_cnt_next
   import mod_cnt_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up,
   input  cnt_mode_e        sat_mode,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] q_d,
   output logic             wrap_p_d,
   output logic             sat_d,
   output logic             at_top,
   output logic             at_bot
);

   logic above_max;

   // A count stranded above a lowered max_val is treated as sitting at the top.
   assign above_max = (q > max_val);
   assign at_top    = (q >= max_val);
   assign at_bot    = (q == '0);

   always_comb begin
      q_d      = q;
      wrap_p_d = 1'b0;
      sat_d    = 1'b0;
      if (clr) begin
         q_d = '0;
      end else if (load) begin
         q_d = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
         if (up) begin
            if (!at_top) begin
               q_d = q + WIDTH'(1);
            end else if (sat_mode == CNT_WRAP) begin
               q_d      = '0;
               wrap_p_d = 1'b1;
            end else begin
               sat_d = 1'b1;
            end
         end else begin
            if (above_max) begin
               q_d = max_val;
            end else if (!at_bot) begin
               q_d = q - WIDTH'(1);
            end else if (sat_mode == CNT_WRAP) begin
               q_d      = max_val;
               wrap_p_d = 1'b1;
            end else begin
               sat_d = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with wrap/saturate modes and cascade tc.
// Define MOD_CNT_GRAY_OUT_EN to add the registered Gray-coded output q_gray.
module mod_updown_counter
   import mod_cnt_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int RESET_VAL = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mod_updown_counter_if.slave  bus
);

   logic [WIDTH-1:0] q_q,      q_d;
   logic             wrap_p_q, wrap_p_d;
   logic             sat_q,    sat_d;
   logic             at_top,   at_bot;

   mod_cnt_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .q        (q_q),
      .clr      (bus.clr),
      .load     (bus.load),
      .load_val (bus.load_val),
      .en       (bus.en),
      .up       (bus.up),
      .sat_mode (bus.sat_mode),
      .max_val  (bus.max_val),
      .q_d      (q_d),
      .wrap_p_d (wrap_p_d),
      .sat_d    (sat_d),
      .at_top   (at_top),
      .at_bot   (at_bot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q      <= WIDTH'(RESET_VAL);
         wrap_p_q <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         q_q      <= q_d;
         wrap_p_q <= wrap_p_d;
         sat_q    <= sat_d;
      end
   end

   // tc is combinational so a downstream counter can use it directly as en.
   assign bus.tc     = bus.en & (bus.up ? at_top : at_bot);
   assign bus.q      = q_q;
   assign bus.wrap_p = wrap_p_q;
   assign bus.sat    = sat_q;

`ifdef MOD_CNT_GRAY_OUT_EN
   logic [WIDTH-1:0] q_gray_q, q_gray_d;

   // Encoded from q_d so the Gray value changes on the same edge as q.
   assign q_gray_d = WIDTH'(bin2gray(CNT_GRAY_W'(q_d)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_gray_q <= WIDTH'(bin2gray(CNT_GRAY_W'(RESET_VAL)));
      end else begin
         q_gray_q <= q_gray_d;
      end
   end

   assign bus.q_gray = q_gray_q;
`endif

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter (WIDTH=4, RESET_VAL=3).
module tb_mod_updown_counter;
   import mod_cnt_pkg::*;

   localparam int WIDTH = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   mod_updown_counter_if #(.WIDTH(WIDTH)) bus ();

   mod_updown_counter #(
      .WIDTH     (WIDTH),
      .RESET_VAL (3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n        = 1'b0;
      bus.clr      = 1'b0;
      bus.load     = 1'b0;
      bus.load_val = '0;
      bus.en       = 1'b0;
      bus.up       = 1'b1;
      bus.sat_mode = CNT_WRAP;
      bus.max_val  = 4'd9;
      step();
      step();
      chk("rst_q", 32'(bus.q), 32'd3);
      chk("rst_wrap", 32'(bus.wrap_p), 32'd0);
      chk("rst_sat", 32'(bus.sat), 32'd0);
      chk("rst_tc", 32'(bus.tc), 32'd0);
`ifdef MOD_CNT_GRAY_OUT_EN
      chk("rst_gray", 32'(bus.q_gray), 32'd2);
`endif
      rst_n   = 1'b1;
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      chk("clr_q", 32'(bus.q), 32'd0);

      // Wrap counting 0..9,0,1
      bus.en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         chk($sformatf("t1_q%0d", i), 32'(bus.q), 32'(i % 10));
         chk($sformatf("t1_tc%0d", i), 32'(bus.tc), 32'((i % 10) == 9));
         chk($sformatf("t1_wrap%0d", i), 32'(bus.wrap_p), 32'(i == 10));
         step();
      end
      chk("t1_end_q", 32'(bus.q), 32'd2);
      chk("t1_end_wrap", 32'(bus.wrap_p), 32'd0);

      // Saturating down count from 2
      bus.up       = 1'b0;
      bus.sat_mode = CNT_SAT;
      #1;
      chk("t2_tc_q2", 32'(bus.tc), 32'd0);
      step();
      chk("t2_q1", 32'(bus.q), 32'd1);
      chk("t2_sat1", 32'(bus.sat), 32'd0);
      step();
      chk("t2_q2", 32'(bus.q), 32'd0);
      chk("t2_sat2", 32'(bus.sat), 32'd0);
      chk("t2_tc_q0", 32'(bus.tc), 32'd1);
      step();
      chk("t2_q3", 32'(bus.q), 32'd0);
      chk("t2_sat3", 32'(bus.sat), 32'd1);
      chk("t2_wrap3", 32'(bus.wrap_p), 32'd0);
      step();
      chk("t2_q4", 32'(bus.q), 32'd0);
      chk("t2_sat4", 32'(bus.sat), 32'd1);
      chk("t2_wrap4", 32'(bus.wrap_p), 32'd0);

      // Load above max clamps; then up wraps
      bus.en       = 1'b0;
      bus.up       = 1'b1;
      bus.sat_mode = CNT_WRAP;
      bus.load     = 1'b1;
      bus.load_val = 4'd12;
      step();
      bus.load = 1'b0;
      chk("t3_load_q", 32'(bus.q), 32'd9);
      chk("t3_load_sat", 32'(bus.sat), 32'd0);
      bus.en = 1'b1;
      #1;
      chk("t3_tc", 32'(bus.tc), 32'd1);
      step();
      chk("t3_wrap_q", 32'(bus.q), 32'd0);
      chk("t3_wrap_p", 32'(bus.wrap_p), 32'd1);
      bus.en = 1'b0;
      step();
      chk("t3_hold_q", 32'(bus.q), 32'd0);
      chk("t3_wrap_clear", 32'(bus.wrap_p), 32'd0);

      // Priority: clr beats load and en
      bus.load     = 1'b1;
      bus.load_val = 4'd5;
      step();
      chk("t4_load5", 32'(bus.q), 32'd5);
`ifdef MOD_CNT_GRAY_OUT_EN
      chk("t4_gray5", 32'(bus.q_gray), 32'd7);
`endif
      bus.clr      = 1'b1;
      bus.en       = 1'b1;
      bus.load_val = 4'd7;
      step();
      chk("t4_clr_all", 32'(bus.q), 32'd0);
      bus.clr      = 1'b0;
      bus.en       = 1'b0;
      bus.load_val = 4'd5;
      step();
      chk("t4_reload5", 32'(bus.q), 32'd5);
      bus.clr = 1'b1;
      step();
      chk("t4_clr_load", 32'(bus.q), 32'd0);
      bus.clr = 1'b0;

      // q above a lowered max_val: up wraps, down snaps to max
      bus.load_val = 4'd8;
      step();
      bus.load    = 1'b0;
      bus.max_val = 4'd5;
      bus.en      = 1'b1;
      bus.up      = 1'b1;
      #1;
      chk("t5_tc_up", 32'(bus.tc), 32'd1);
      step();
      chk("t5_up_q", 32'(bus.q), 32'd0);
      chk("t5_up_wrap", 32'(bus.wrap_p), 32'd1);
      bus.en      = 1'b0;
      bus.max_val = 4'd9;
      bus.load    = 1'b1;
      step();
      bus.load    = 1'b0;
      chk("t5_reload8", 32'(bus.q), 32'd8);
      bus.max_val = 4'd5;
      bus.en      = 1'b1;
      bus.up      = 1'b0;
      #1;
      chk("t5_tc_dn", 32'(bus.tc), 32'd0);
      step();
      chk("t5_dn_q", 32'(bus.q), 32'd5);
      chk("t5_dn_wrap", 32'(bus.wrap_p), 32'd0);

      // max_val == 0: every enabled edge wraps or saturates
      bus.en      = 1'b0;
      bus.clr     = 1'b1;
      step();
      bus.clr     = 1'b0;
      bus.max_val = 4'd0;
      bus.en      = 1'b1;
      bus.up      = 1'b1;
      step();
      chk("m0_q_a", 32'(bus.q), 32'd0);
      chk("m0_wrap_a", 32'(bus.wrap_p), 32'd1);
      step();
      chk("m0_wrap_b", 32'(bus.wrap_p), 32'd1);
      bus.sat_mode = CNT_SAT;
      bus.up       = 1'b0;
      step();
      chk("m0_q_s", 32'(bus.q), 32'd0);
      chk("m0_sat", 32'(bus.sat), 32'd1);
      chk("m0_wrap_s", 32'(bus.wrap_p), 32'd0);

      // Asynchronous reset mid-count
      bus.sat_mode = CNT_WRAP;
      bus.max_val  = 4'd9;
      bus.en       = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 4'd7;
      step();
      bus.load = 1'b0;
      bus.en   = 1'b1;
      bus.up   = 1'b1;
      chk("t6_q7", 32'(bus.q), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_q", 32'(bus.q), 32'd3);
      chk("t6_async_wrap", 32'(bus.wrap_p), 32'd0);
`ifdef MOD_CNT_GRAY_OUT_EN
      chk("t6_async_gray", 32'(bus.q_gray), 32'd2);
`endif
      step();
      rst_n = 1'b1;
      step();
      chk("t6_resume_q", 32'(bus.q), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
